gated_shift_ctrl: RTL

- Parametrised benchmark-class sequential controller for the benchmark suite.
- NCH independent DEPTH-stage shift channels run under a 4-state mode FSM with a wrap counter.
- Per-channel outputs are gated by primary-input enables and driven true and complemented (BF).
- A full scan chain threads every channel flop, so the block serves as a scalable, scan-testable benchmark core.

---
 rtl/gated_shift_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/gated_shift_ctrl.sv
// NCH independent DEPTH-stage shift channels under a 4-state mode FSM with a
// RUN-cycle wrap counter, gated true/complement outputs and a full scan chain.
module gated_shift_ctrl #(
  parameter int NCH   = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [NCH-1:0]   DIN,
  input  logic [NCH-1:0]   GATE,
  input  logic             SCAN_EN,
  input  logic             SCAN_IN,
  output logic [NCH-1:0]   Q,
  output logic [NCH-1:0]   QBF,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] CNT,
  output logic             WRAP,
  output logic             BUSY,
  output logic             SCAN_OUT
);

  localparam int CHAIN = NCH * DEPTH;
  localparam int FC_W  = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_HOLD  = 2'b10,
    S_FLUSH = 2'b11
  } state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [FC_W-1:0]                 fcnt_q, fcnt_d;
  logic                            wrap_q, wrap_d;
  logic [NCH-1:0][DEPTH-1:0]       stage_q, stage_d;
  logic [NCH-1:0][DEPTH-1:0]       shifted;
  logic [CHAIN-1:0]                chain;
  logic [NCH-1:0]                  shin;

  // Flat view: bit c*DEPTH+k is stage[c][k], which is exactly the scan order.
  assign chain = stage_q;
  assign shin  = (state_q == S_RUN) ? DIN : '0;

  always_comb begin
    for (int c = 0; c < NCH; c++)
      shifted[c] = {stage_q[c][DEPTH-2:0], shin[c]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    stage_d = stage_q;
    wrap_d  = 1'b0;
    if (SCAN_EN) begin
      stage_d = {chain[CHAIN-2:0], SCAN_IN};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (EN && MODE == 2'b01) begin
            state_d = S_RUN;
          end else if (EN && MODE == 2'b11) begin
            state_d = S_FLUSH;
            fcnt_d  = '0;
          end
        end
        S_RUN: begin
          stage_d = shifted;
          cnt_d   = cnt_q + CNT_W'(1);
          wrap_d  = &cnt_q;
          if (!EN) begin
            state_d = S_IDLE;
          end else if (MODE == 2'b10) begin
            state_d = S_HOLD;
          end else if (MODE == 2'b11) begin
            state_d = S_FLUSH;
            fcnt_d  = '0;
          end
        end
        S_HOLD: begin
          if (!EN) begin
            state_d = S_IDLE;
          end else if (MODE == 2'b01) begin
            state_d = S_RUN;
          end else if (MODE == 2'b11) begin
            state_d = S_FLUSH;
            fcnt_d  = '0;
          end
        end
        default: begin
          // FLUSH lasts DEPTH edges, enough to push zeros through every stage.
          stage_d = shifted;
          fcnt_d  = fcnt_q + FC_W'(1);
          if (fcnt_q == FC_W'(DEPTH - 1)) state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      wrap_q  <= 1'b0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      wrap_q  <= wrap_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++)
      Q[c] = stage_q[c][DEPTH-1] & GATE[c];
  end

  assign QBF      = ~Q;
  assign STATE    = state_q;
  assign CNT      = cnt_q;
  assign WRAP     = wrap_q;
  assign BUSY     = (state_q != S_IDLE);
  assign SCAN_OUT = stage_q[NCH-1][DEPTH-1];

endmodule
